// File: rtl/systolic_pkg.sv
// Shared state encoding, accumulator sizing and flat-bus index helpers for the
// N x N output-stationary systolic multiplier.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // N products of 2*DW bits need clog2(N) extra bits to never overflow.
    function automatic int acc_w(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int a_lsb(input int i, input int dw);
        return i * dw;
    endfunction

    function automatic int b_lsb(input int j, input int dw);
        return j * dw;
    endfunction

    function automatic int c_lsb(input int i, input int j, input int n, input int aw);
        return (i * n + j) * aw;
    endfunction

endpackage

// File: rtl/systolic_array_nxn_pe.sv
// Single MAC cell: forwards a east and b south through one register each and
// accumulates a*b into an output-stationary accumulator when both tags are set.
module systolic_pe #(
    parameter int DW     = 8,
    parameter int AW     = 17,
    parameter bit SIGNED = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic [DW-1:0] a_i,
    input  logic          ta_i,
    input  logic [DW-1:0] b_i,
    input  logic          tb_i,
    output logic [DW-1:0] a_o,
    output logic          ta_o,
    output logic [DW-1:0] b_o,
    output logic          tb_o,
    output logic [AW-1:0] acc_o
);
    logic [DW-1:0]          a_q, b_q;
    logic                   ta_q, tb_q;
    logic [AW-1:0]          acc_q, acc_d;
    logic signed [2*DW-1:0] a_x, b_x, prod;
    logic [AW-1:0]          prod_ext;

    always_comb begin
        a_x      = SIGNED ? {{DW{a_i[DW-1]}}, a_i} : {{DW{1'b0}}, a_i};
        b_x      = SIGNED ? {{DW{b_i[DW-1]}}, b_i} : {{DW{1'b0}}, b_i};
        prod     = a_x * b_x;
        prod_ext = SIGNED ? {{(AW-2*DW){prod[2*DW-1]}}, prod}
                          : {{(AW-2*DW){1'b0}}, prod};
        acc_d    = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (ta_i && tb_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            ta_q  <= 1'b0;
            tb_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            ta_q  <= ta_i;
            tb_q  <= tb_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign ta_o  = ta_q;
    assign tb_o  = tb_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary systolic multiplier: beat FSM, internal operand skew,
// and a grid of MAC cells whose accumulators drive c_out directly.
module systolic_array_nxn
    import systolic_pkg::*;
#(
    parameter int N      = 2,
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0,
    parameter int AW     = acc_w(DW, N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   a_in,
    input  logic [N*DW-1:0]   b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*N*AW-1:0] c_out,
    output logic              done
);
    localparam int            CW         = $clog2(2 * N);
    localparam logic [CW-1:0] LAST_BEAT  = CW'(N - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(2 * N - 2);

    state_e        state_q, state_d;
    logic [CW-1:0] beat_q, beat_d, drain_q, drain_d;
    logic          done_q, done_d;
    logic          accept, clr;

    assign accept = in_valid && in_ready;
    assign clr    = (state_q == DONE) && out_ready;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = LOAD;
                    beat_d  = CW'(1);
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            // Wait until the last beat has swept through PE(N-1,N-1).
            DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

    logic [DW-1:0] a_edge [N];
    logic [DW-1:0] b_edge [N];
    logic          t_edge [N];
    logic [DW-1:0] a_pe   [N][N];
    logic [DW-1:0] b_pe   [N][N];
    logic          ta_pe  [N][N];
    logic          tb_pe  [N][N];
    logic [AW-1:0] acc_pe [N][N];

    // Stage 0 captures the beat; row i of A and column i of B then see i more delays.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic [DW-1:0] a_sk_q [gi+1];
        logic [DW-1:0] b_sk_q [gi+1];
        logic          t_sk_q [gi+1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= gi; s++) begin
                    a_sk_q[s] <= '0;
                    b_sk_q[s] <= '0;
                    t_sk_q[s] <= 1'b0;
                end
            end else begin
                a_sk_q[0] <= a_in[a_lsb(gi, DW) +: DW];
                b_sk_q[0] <= b_in[b_lsb(gi, DW) +: DW];
                t_sk_q[0] <= accept;
                for (int s = 1; s <= gi; s++) begin
                    a_sk_q[s] <= a_sk_q[s-1];
                    b_sk_q[s] <= b_sk_q[s-1];
                    t_sk_q[s] <= t_sk_q[s-1];
                end
            end
        end

        assign a_edge[gi] = a_sk_q[gi];
        assign b_edge[gi] = b_sk_q[gi];
        assign t_edge[gi] = t_sk_q[gi];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [DW-1:0] a_w, b_n;
            logic          ta_w, tb_n;

            if (gj == 0) begin : g_west
                assign a_w  = a_edge[gi];
                assign ta_w = t_edge[gi];
            end else begin : g_east
                assign a_w  = a_pe[gi][gj-1];
                assign ta_w = ta_pe[gi][gj-1];
            end

            if (gi == 0) begin : g_north
                assign b_n  = b_edge[gj];
                assign tb_n = t_edge[gj];
            end else begin : g_south
                assign b_n  = b_pe[gi-1][gj];
                assign tb_n = tb_pe[gi-1][gj];
            end

            systolic_pe #(
                .DW     (DW),
                .AW     (AW),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr_i (clr),
                .a_i   (a_w),
                .ta_i  (ta_w),
                .b_i   (b_n),
                .tb_i  (tb_n),
                .a_o   (a_pe[gi][gj]),
                .ta_o  (ta_pe[gi][gj]),
                .b_o   (b_pe[gi][gj]),
                .tb_o  (tb_pe[gi][gj]),
                .acc_o (acc_pe[gi][gj])
            );

            assign c_out[c_lsb(gi, gj, N, AW) +: AW] = acc_pe[gi][gj];
        end
    end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Directed bench for systolic_array_nxn: a 2x2 unsigned and a 4x4 signed instance.
module tb_systolic_array_nxn;
    localparam int AW2 = 17;
    localparam int AW4 = 18;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              iv2, ir2, ov2, or2, dn2;
    logic [15:0]       a2, b2;
    logic [4*AW2-1:0]  c_out2;
    logic              iv4, ir4, ov4, or4, dn4;
    logic [31:0]       a4, b4;
    logic [16*AW4-1:0] c_out4;

    systolic_array_nxn #(.N(2), .DW(8), .SIGNED(1'b0)) dut2 (
        .clk(clk), .rst(rst_n), .in_valid(iv2), .in_ready(ir2), .a_in(a2), .b_in(b2),
        .out_valid(ov2), .out_ready(or2), .c_out(c_out2), .done(dn2));

    systolic_array_nxn #(.N(4), .DW(8), .SIGNED(1'b1)) dut4 (
        .clk(clk), .rst(rst_n), .in_valid(iv4), .in_ready(ir4), .a_in(a4), .b_in(b4),
        .out_valid(ov4), .out_ready(or4), .c_out(c_out4), .done(dn4));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt2 = 0;
    logic [4*AW2-1:0] snap2;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ov2) snap2 <= c_out2;
        if (dn2) done_cnt2 <= done_cnt2 + 1;
    end

    typedef struct {
        logic [15:0] a0, b0, a1, b1;
        int          gap;
        int          e0, e1, e2, e3;
    } vec2_t;

    vec2_t tbl [5];
    int    bm  [4][4] = '{'{-128, 127, -1, 0}, '{5, -6, 7, -8},
                          '{100, -100, 50, -50}, '{1, 2, 3, 4}};

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat2(input logic [15:0] a, input logic [15:0] b);
        int w = 0;
        while (!ir2 && w < 50) begin tick(); w++; end
        check("beat2 in_ready", ir2, 1);
        iv2 = 1'b1; a2 = a; b2 = b;
        tick();
        iv2 = 1'b0;
    endtask

    task automatic beat4(input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        while (!ir4 && w < 50) begin tick(); w++; end
        check("beat4 in_ready", ir4, 1);
        iv4 = 1'b1; a4 = a; b4 = b;
        tick();
        iv4 = 1'b0;
    endtask

    task automatic wait_ov2(output int lat);
        lat = 0;
        while (!ov2 && lat < 40) begin tick(); lat++; end
    endtask

    task automatic wait_ov4(output int lat);
        lat = 0;
        while (!ov4 && lat < 40) begin tick(); lat++; end
    endtask

    task automatic check_c2(input string name, input logic [4*AW2-1:0] c, input vec2_t v);
        int e [4];
        e = '{v.e0, v.e1, v.e2, v.e3};
        for (int k = 0; k < 4; k++)
            check($sformatf("%s C%0d%0d", name, k / 2, k % 2), c[k*AW2 +: AW2], e[k]);
    endtask

    task automatic handshake2(input string name);
        or2 = 1'b1;
        tick();
        or2 = 1'b0;
        check({name, " done"}, dn2, 1);
        check({name, " out_valid low"}, ov2, 0);
        check({name, " in_ready"}, ir2, 1);
        check({name, " cleared"}, (c_out2 == '0), 1);
        tick();
        check({name, " done one cycle"}, dn2, 0);
    endtask

    task automatic run2(input string name, input vec2_t v);
        int lat;
        or2 = 1'b0;
        beat2(v.a0, v.b0);
        repeat (v.gap) tick();
        beat2(v.a1, v.b1);
        wait_ov2(lat);
        check({name, " latency"}, lat, 3);
        check_c2(name, c_out2, v);
        handshake2(name);
    endtask

    initial begin : main
        int lat, d0, t0, t1;
        logic [4*AW2-1:0] hold;
        logic [31:0] av, bv;

        tbl[0] = '{16'h0301, 16'h0605, 16'h0402, 16'h0807, 0, 19, 22, 43, 50};
        tbl[1] = '{16'h0301, 16'h0605, 16'h0402, 16'h0807, 2, 19, 22, 43, 50};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 130050, 130050, 130050, 130050};
        tbl[3] = '{16'h0100, 16'h0809, 16'h0001, 16'h0607, 1, 7, 6, 9, 8};
        tbl[4] = '{16'h0002, 16'h140A, 16'h0300, 16'h281E, 3, 20, 40, 90, 120};

        rst_n = 1'b0;
        iv2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0;
        iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset in_ready", ir2, 1);
        check("reset out_valid", ov2, 0);
        check("reset done", dn2, 0);
        check("reset c_out", (c_out2 == '0), 1);
        check("reset4 in_ready", ir4, 1);
        check("reset4 c_out", (c_out4 == '0), 1);

        for (int t = 0; t < 5; t++) run2($sformatf("vec%0d", t), tbl[t]);

        // Result held in DONE while the consumer stalls.
        beat2(tbl[0].a0, tbl[0].b0);
        beat2(tbl[0].a1, tbl[0].b1);
        wait_ov2(lat);
        check("stall latency", lat, 3);
        hold = c_out2;
        check_c2("stall", hold, tbl[0]);
        d0 = done_cnt2;
        for (int k = 0; k < 10; k++) begin
            iv2 = 1'b1; a2 = 16'hFFFF; b2 = 16'hFFFF;
            tick();
            check("stall c_out stable", (c_out2 == hold), 1);
            check("stall out_valid", ov2, 1);
            check("stall in_ready low", ir2, 0);
        end
        iv2 = 1'b0;
        handshake2("stall");
        check("stall done count", done_cnt2 - d0, 1);
        run2("after stall", tbl[4]);

        // Asynchronous reset in the middle of DRAIN.
        beat2(tbl[0].a0, tbl[0].b0);
        beat2(tbl[0].a1, tbl[0].b1);
        tick();
        check("pre-reset partial", (c_out2 != '0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset in_ready", ir2, 1);
        check("mid reset out_valid", ov2, 0);
        check("mid reset done", dn2, 0);
        check("mid reset c_out", (c_out2 == '0), 1);
        #2 rst_n = 1'b1;
        tick();
        run2("after reset", tbl[0]);

        // Back-to-back matrices with out_ready held high.
        or2 = 1'b1;
        beat2(tbl[0].a0, tbl[0].b0);
        t0 = cyc;
        beat2(tbl[0].a1, tbl[0].b1);
        beat2(tbl[4].a0, tbl[4].b0);
        t1 = cyc;
        check("b2b period", t1 - t0, 6);
        check_c2("b2b first", snap2, tbl[0]);
        beat2(tbl[4].a1, tbl[4].b1);
        wait_ov2(lat);
        check("b2b latency", lat, 3);
        check_c2("b2b second", c_out2, tbl[4]);
        tick();
        or2 = 1'b0;
        check("b2b done", dn2, 1);

        // N=4 signed: identity times B.
        for (int k = 0; k < 4; k++) begin
            av = 32'h1 << (8 * k);
            for (int j = 0; j < 4; j++) bv[j*8 +: 8] = 8'(bm[k][j]);
            beat4(av, bv);
        end
        wait_ov4(lat);
        check("n4 latency", lat, 7);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check($sformatf("n4 ident C%0d%0d", i, j),
                      $signed(c_out4[(i*4+j)*AW4 +: AW4]), bm[i][j]);
        or4 = 1'b1;
        tick();
        or4 = 1'b0;
        check("n4 done", dn4, 1);
        check("n4 cleared", (c_out4 == '0), 1);

        // N=4 signed: most negative operands everywhere.
        for (int k = 0; k < 4; k++) beat4(32'h80808080, 32'h80808080);
        wait_ov4(lat);
        check("n4 min latency", lat, 7);
        for (int i = 0; i < 16; i++)
            check($sformatf("n4 min C%0d%0d", i / 4, i % 4),
                  $signed(c_out4[i*AW4 +: AW4]), 65536);
        or4 = 1'b1;
        tick();
        or4 = 1'b0;
        check("n4 min done", dn4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, limit 1000000 expected earlier");
        $fatal(1);
    end

endmodule

// File: doc/systolic_array_nxn.md
# systolic_array_nxn

Parametrised N×N output-stationary systolic matrix multiplier, the successor to the fixed 2×2 array. It accepts one column of A and one row of B per handshake beat, skews operands internally so callers no longer pre-stagger inputs, and accumulates C = A·B in an N×N grid of MAC cells. It presents the full result matrix behind a valid/ready handshake. It sits between the operand staging buffers and the result writeback path.

## Interface
- N, default 2: matrix dimension, N ≥ 2.
- DW, default 8: operand width.
- SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands and products.
- AW, default 2*DW + $clog2(N): accumulator width. Overflow-free for any N beats; values smaller than the default are illegal.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- a_in  in  N*DW  A column k; A[i][k] at bits [i*DW +: DW].
- b_in  in  N*DW  B row k; B[k][j] at bits [j*DW +: DW].
- out_valid  out  1  c_out holds a complete result.
- out_ready  in  1  consumer accepts the result.
- c_out  out  N*N*AW  C[i][j] at bits [(i*N+j)*AW +: AW].
- done  out  1  one-cycle pulse on the edge the result handshake completes.

## Operation
- FSM states:
  - IDLE: in_ready=1. An accepted beat moves to LOAD with beat count 1.
  - LOAD: in_ready=1. The accepted beat with count N-1 moves to DRAIN.
  - DRAIN: in_ready=0. Holds for exactly 2N-1 edges, then moves to DONE.
  - DONE: in_ready=0, out_valid=1. On out_valid&&out_ready, moves to IDLE and pulses done.
- A beat is accepted on an edge with in_valid&&in_ready.
- Gaps in in_valid during LOAD are allowed. No data is consumed and the beat count is unchanged.
- Skew: row i of A passes through i skew registers, column j of B through j. Each operand carries a valid tag through the skew chains and the PE chains.
- Each PE(i,j) forwards a to the east and b to the south with one register each. It accumulates a·b only when the tag is set, so gap bubbles add nothing.
- Products are 2*DW wide, sign- or zero-extended to AW per SIGNED. Accumulation wraps modulo 2^AW, which cannot occur at the default AW.
- All accumulators clear on reset and on the result-handshake edge.
- c_out is driven directly from the accumulators. It is stable throughout DONE and reads 0 in IDLE.
- in_valid asserted while in_ready=0 is ignored. No beat is lost or counted.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, done=0, c_out=0, all skew, PE and tag registers 0.
- If the last beat (k=N-1) is accepted at edge e, PE(i,j) applies it at edge e+i+j+1. PE(N-1,N-1) finishes at e+2N-1.
- out_valid rises at that same edge e+2N-1. For N=2 that is 3 edges after the last beat.
- Throughput: with back-to-back beats and out_ready held at 1, one matrix every 3N cycles.
- Result handshake at edge h: out_valid falls, done=1 for the cycle after h, and in_ready=1 from h.
- Reset asserted mid-operation: all state clears immediately and asynchronously. The partial computation is discarded and no done pulse is generated.

## Structure
- Package systolic_pkg holds:
  - the state enum (IDLE, LOAD, DRAIN, DONE);
  - the default accumulator-width function acc_w(DW, N);
  - the flat-index helpers for a_in, b_in and c_out.
- Sub-module systolic_pe is a single MAC cell: registered a/b/tag pass-through plus the accumulator, with a clear input and the SIGNED parameter.
- The top level contains the FSM, beat and drain counters, skew chains, and a generate-based N×N PE grid.

## Test plan
- N=2, DW=8, unsigned. Beats (a_in,b_in) = ([1,3],[5,6]) then ([2,4],[7,8]) back-to-back -> out_valid at the 3rd edge after beat 1, C = [[19,22],[43,50]], done pulse on handshake.
- Same operands with a 2-cycle in_valid gap between beats -> identical C and identical latency measured from the last beat.
- N=4, SIGNED=1, A = identity, B with entries in -128..127 -> C = B. All-(-128) A and B -> every C[i][j] = 65536 with no overflow.
- out_ready held low for 10 cycles in DONE -> c_out stable, in_valid pulses ignored, done fires once on release, next matrix is correct.
- rst asserted during DRAIN -> all outputs at reset values immediately. The next full transaction gives the correct C with no residue.
- Back-to-back matrices with out_ready=1 -> second result is independent of the first because the accumulators were cleared.
